fetch2_stage: RTL and testbench

// - Second instruction-fetch stage. Takes the PC and fetch-valid from Fetch1, collects the ICache

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch2_stage_if.sv | 30 +++
 rtl/fetch2_skid_buf.sv | 30 +++
 rtl/fetch2_stage.sv | 111 +++++++++++
 tb/tb_fetch2_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and exception codes for the instruction-fetch pipeline.
package fetch_pkg;

  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch2_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [5:0]  ecode;
  } fetch_entry_t;

  // A misaligned PC reports ADEF even when the ITLB also faulted.
  function automatic fetch_entry_t fault_entry(logic [31:0] pc, logic [5:0] tlb_ecode);
    fetch_entry_t e;
    e.pc    = pc;
    e.inst  = '0;
    e.exc   = 1'b1;
    e.ecode = (pc[1:0] != 2'b00) ? ECODE_ADEF : tlb_ecode;
    return e;
  endfunction

endpackage

// File: rtl/fetch2_stage_if.sv
// Fetch2 boundary: Fetch1 request, ICache response, ITLB fault and Decode handshake.
interface fetch2_stage_if;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        flush_i;
  logic        stall_i;
  logic        ic_rvalid_i;
  logic [31:0] ic_rdata_i;
  logic        tlb_exc_i;
  logic [5:0]  tlb_ecode_i;

  logic        ic_cancel_o;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        exc_o;
  logic [5:0]  ecode_o;
  logic        is_tlbr_o;

  modport master (
    output pc_i, valid_i, flush_i, stall_i, ic_rvalid_i, ic_rdata_i, tlb_exc_i, tlb_ecode_i,
    input  ic_cancel_o, stall_o, valid_o, pc_o, inst_o, exc_o, ecode_o, is_tlbr_o
  );

  modport slave (
    input  pc_i, valid_i, flush_i, stall_i, ic_rvalid_i, ic_rdata_i, tlb_exc_i, tlb_ecode_i,
    output ic_cancel_o, stall_o, valid_o, pc_o, inst_o, exc_o, ecode_o, is_tlbr_o
  );
endinterface

// File: rtl/fetch2_skid_buf.sv
// One-entry holding register behind the Fetch2 output register.
module fetch2_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  // Push wins over pop so a simultaneous drain and refill keeps the slot occupied.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch2_stage.sv
// Second fetch stage: pairs the Fetch1 PC with its ICache response and hands
// {pc, inst, exception} to Decode through an output register plus skid slot.
module fetch2_stage
  import fetch_pkg::*;
(
  input logic           clk,
  input logic           rstn,
  fetch2_stage_if.slave bus
);

  fetch2_state_t state, state_nxt;
  logic [31:0]   req_pc;
  fetch_entry_t  out_q, out_d, resp_e, fault_e, push_e, skid_e;
  logic          out_vld_q, out_vld_d;
  logic          skid_full, skid_push, skid_pop;
  logic          fault, accept, resp_vld, can_load, stall;

  assign fault    = (bus.pc_i[1:0] != 2'b00) || bus.tlb_exc_i;
  assign resp_vld = (state == WAIT) && bus.ic_rvalid_i;
  assign can_load = !out_vld_q || !bus.stall_i;
  assign stall    = ((state == WAIT) && !bus.ic_rvalid_i) || (state == DROP) || skid_full
                    || (out_vld_q && bus.stall_i && resp_vld);
  assign accept   = bus.valid_i && !stall && !bus.flush_i;
  assign resp_e   = '{pc: req_pc, inst: bus.ic_rdata_i, exc: 1'b0, ecode: 6'h0};
  assign fault_e  = fault_entry(bus.pc_i, bus.tlb_ecode_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !fault) req_pc <= bus.pc_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !fault) state_nxt = WAIT;
      WAIT: begin
        if (bus.flush_i)          state_nxt = bus.ic_rvalid_i ? IDLE : DROP;
        else if (bus.ic_rvalid_i) state_nxt = (accept && !fault) ? WAIT : IDLE;
      end
      DROP: if (bus.ic_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Oldest first: skid, then this cycle's ICache response, then a same-cycle fault.
  // Whatever the output register cannot take lands in the skid slot.
  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    push_e    = resp_e;
    if (can_load) begin
      out_vld_d = 1'b1;
      if (skid_full) begin
        out_d     = skid_e;
        skid_pop  = 1'b1;
        skid_push = resp_vld;
      end else if (resp_vld) begin
        out_d     = resp_e;
        skid_push = accept && fault;
        push_e    = fault_e;
      end else if (accept && fault) begin
        out_d = fault_e;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      skid_push = resp_vld || (accept && fault);
      push_e    = resp_vld ? resp_e : fault_e;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (bus.flush_i) begin
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  fetch2_skid_buf u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .clear (bus.flush_i),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (push_e),
    .dout  (skid_e),
    .full  (skid_full)
  );

  assign bus.ic_cancel_o = accept && fault;
  assign bus.stall_o     = stall;
  assign bus.valid_o     = out_vld_q;
  assign bus.pc_o        = out_q.pc;
  assign bus.inst_o      = out_q.inst;
  assign bus.exc_o       = out_q.exc;
  assign bus.ecode_o     = out_q.ecode;
  assign bus.is_tlbr_o   = out_q.exc && (out_q.ecode == ECODE_TLBR);

endmodule

// File: tb/tb_fetch2_stage.sv
// Directed scenarios plus a randomized run against a queue-based model of Fetch2.
module tb_fetch2_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  fetch2_stage_if bus ();

  fetch2_stage dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.pc_i = '0; bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.stall_i = 1'b0;
    bus.ic_rvalid_i = 1'b0; bus.ic_rdata_i = '0; bus.tlb_exc_i = 1'b0; bus.tlb_ecode_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    #12;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.valid_o); end
    total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", bus.pc_o); end
    total++; if (bus.inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", bus.inst_o); end
    total++; if (bus.ecode_o !== 6'h0 || bus.exc_o !== 1'b0 || bus.is_tlbr_o !== 1'b0) begin
      bad++; $display("FAIL reset_exc got=%b/%h/%b want=0/0/0", bus.exc_o, bus.ecode_o, bus.is_tlbr_o); end
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", bus.stall_o); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_aligned_hit();
    bus.valid_i = 1'b1; bus.pc_i = 32'h1C00_0000; #1;
    total++; if (bus.stall_o !== 1'b0 || bus.ic_cancel_o !== 1'b0) begin
      bad++; $display("FAIL hit_accept got stall=%0b cancel=%0b want 0/0", bus.stall_o, bus.ic_cancel_o); end
    tick();
    bus.valid_i = 1'b0; bus.ic_rvalid_i = 1'b1; bus.ic_rdata_i = 32'h0280_0421; #1;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL hit_early_valid got=%0b want=0", bus.valid_o); end
    tick();
    bus.ic_rvalid_i = 1'b0; #1;
    total++; if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h1C00_0000 || bus.inst_o !== 32'h0280_0421 || bus.exc_o !== 1'b0) begin
      bad++; $display("FAIL hit_out got v=%0b pc=%h inst=%h exc=%0b want 1/1c000000/02800421/0",
                      bus.valid_o, bus.pc_o, bus.inst_o, bus.exc_o); end
    tick();
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL hit_drain got=%0b want=0", bus.valid_o); end
  endtask

  task automatic test_misaligned();
    bus.valid_i = 1'b1; bus.pc_i = 32'h1C00_0002; #1;
    total++; if (bus.ic_cancel_o !== 1'b1) begin bad++; $display("FAIL adef_cancel got=%0b want=1", bus.ic_cancel_o); end
    tick();
    bus.valid_i = 1'b0; #1;
    total++; if (bus.valid_o !== 1'b1 || bus.exc_o !== 1'b1 || bus.ecode_o !== 6'h08 || bus.inst_o !== 32'h0
                 || bus.pc_o !== 32'h1C00_0002 || bus.is_tlbr_o !== 1'b0) begin
      bad++; $display("FAIL adef_out got v=%0b exc=%0b ecode=%h inst=%h pc=%h tlbr=%0b want 1/1/08/0/1c000002/0",
                      bus.valid_o, bus.exc_o, bus.ecode_o, bus.inst_o, bus.pc_o, bus.is_tlbr_o); end
    tick();
  endtask

  task automatic test_tlb_refill();
    bus.valid_i = 1'b1; bus.pc_i = 32'h1C00_0010; bus.tlb_exc_i = 1'b1; bus.tlb_ecode_i = 6'h3F; #1;
    total++; if (bus.ic_cancel_o !== 1'b1) begin bad++; $display("FAIL tlbr_cancel got=%0b want=1", bus.ic_cancel_o); end
    tick();
    idle_inputs(); #1;
    total++; if (bus.valid_o !== 1'b1 || bus.exc_o !== 1'b1 || bus.is_tlbr_o !== 1'b1 || bus.ecode_o !== 6'h3F) begin
      bad++; $display("FAIL tlbr_out got v=%0b exc=%0b tlbr=%0b ecode=%h want 1/1/1/3f",
                      bus.valid_o, bus.exc_o, bus.is_tlbr_o, bus.ecode_o); end
    total++; if (dut.state !== IDLE || bus.stall_o !== 1'b0) begin
      bad++; $display("FAIL tlbr_idle got state=%0d stall=%0b want IDLE/0", dut.state, bus.stall_o); end
    tick();
  endtask

  task automatic test_miss_flush();
    bus.valid_i = 1'b1; bus.pc_i = 32'h1C00_0020; #1;
    tick();
    bus.valid_i = 1'b0; #1;
    total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL miss_wait_stall got=%0b want=1", bus.stall_o); end
    tick();
    bus.flush_i = 1'b1; #1;
    tick();
    bus.flush_i = 1'b0; #1;
    total++; if (dut.state !== DROP || bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL miss_drop got state=%0d stall=%0b want DROP/1", dut.state, bus.stall_o); end
    tick();
    tick();
    bus.ic_rvalid_i = 1'b1; bus.ic_rdata_i = 32'hDEAD_BEEF; #1;
    total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL miss_rvalid_stall got=%0b want=1", bus.stall_o); end
    tick();
    bus.ic_rvalid_i = 1'b0; bus.ic_rdata_i = '0; #1;
    total++; if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0 || dut.state !== IDLE) begin
      bad++; $display("FAIL miss_release got stall=%0b v=%0b state=%0d want 0/0/IDLE", bus.stall_o, bus.valid_o, dut.state); end
    tick();
    total++; if (bus.valid_o !== 1'b0 || bus.inst_o === 32'hDEAD_BEEF) begin
      bad++; $display("FAIL miss_swallow got v=%0b inst=%h want 0/not deadbeef", bus.valid_o, bus.inst_o); end
  endtask

  task automatic test_back_to_back();
    bus.valid_i = 1'b1; bus.pc_i = 32'h1C00_0100; #1;
    tick();
    bus.pc_i = 32'h1C00_0104; bus.ic_rvalid_i = 1'b1; bus.ic_rdata_i = 32'hAAAA_0001; bus.stall_i = 1'b1; #1;
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL b2b_accept2 got=%0b want=0", bus.stall_o); end
    tick();
    bus.valid_i = 1'b0; bus.ic_rdata_i = 32'hAAAA_0002; #1;
    total++; if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h1C00_0100 || bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL b2b_first got v=%0b pc=%h stall=%0b want 1/1c000100/1", bus.valid_o, bus.pc_o, bus.stall_o); end
    tick();
    bus.ic_rvalid_i = 1'b0; #1;
    total++; if (bus.stall_o !== 1'b1 || dut.u_skid.full !== 1'b1) begin
      bad++; $display("FAIL b2b_skid got stall=%0b full=%0b want 1/1", bus.stall_o, dut.u_skid.full); end
    tick();
    tick();
    bus.stall_i = 1'b0; #1;
    total++; if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h1C00_0100 || bus.inst_o !== 32'hAAAA_0001) begin
      bad++; $display("FAIL b2b_hold got v=%0b pc=%h inst=%h want 1/1c000100/aaaa0001", bus.valid_o, bus.pc_o, bus.inst_o); end
    tick();
    total++; if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h1C00_0104 || bus.inst_o !== 32'hAAAA_0002 || bus.stall_o !== 1'b0) begin
      bad++; $display("FAIL b2b_second got v=%0b pc=%h inst=%h stall=%0b want 1/1c000104/aaaa0002/0",
                      bus.valid_o, bus.pc_o, bus.inst_o, bus.stall_o); end
    tick();
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL b2b_nodup got=%0b want=0", bus.valid_o); end
  endtask

  task automatic test_async_reset();
    bus.valid_i = 1'b1; bus.pc_i = 32'h1C00_0202; #1;
    tick();
    bus.pc_i = 32'h1C00_0200; bus.stall_i = 1'b1; #1;
    tick();
    bus.valid_i = 1'b0; #1;
    total++; if (bus.valid_o !== 1'b1 || bus.stall_o !== 1'b1) begin
      bad++; $display("FAIL arst_pre got v=%0b stall=%0b want 1/1", bus.valid_o, bus.stall_o); end
    #2 rstn = 1'b0;
    #1;
    total++; if (bus.valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      bad++; $display("FAIL arst_now got v=%0b stall=%0b want 0/0", bus.valid_o, bus.stall_o); end
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    total++; if (dut.state !== IDLE || bus.stall_o !== 1'b0) begin
      bad++; $display("FAIL arst_idle got state=%0d stall=%0b want IDLE/0", dut.state, bus.stall_o); end
  endtask

  // Model: the stage holds up to two entries in Decode order; at most one ICache
  // response is owed and may be marked for discard after a flush.
  task automatic test_random(input int n);
    fetch_entry_t q[$];
    fetch_entry_t e;
    logic         owed, drop, rv, resp, stall_e, acc, flt;
    logic [31:0]  req_pc, r;
    int           cnt;
    owed = 1'b0; drop = 1'b0; cnt = 0; req_pc = '0;
    for (int i = 0; i < n; i++) begin
      rv = owed && (cnt == 0);
      bus.ic_rvalid_i = rv;
      bus.ic_rdata_i  = $urandom;
      bus.valid_i     = ($urandom_range(0, 9) < 7);
      r               = $urandom;
      bus.pc_i        = {r[31:2], ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      bus.tlb_exc_i   = ($urandom_range(0, 9) == 0);
      bus.tlb_ecode_i = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom_range(0, 63));
      bus.stall_i     = ($urandom_range(0, 9) < 3);
      bus.flush_i     = ($urandom_range(0, 19) == 0);
      #1;
      resp    = owed && !drop && rv;
      stall_e = (owed && !drop && !rv) || (owed && drop) || (q.size() == 2)
                || (q.size() > 0 && bus.stall_i && resp);
      acc     = bus.valid_i && !stall_e && !bus.flush_i;
      flt     = acc && ((bus.pc_i[1:0] != 2'b00) || bus.tlb_exc_i);
      total++; if (bus.stall_o !== stall_e) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0b want=%0b", i, bus.stall_o, stall_e); end
      total++; if (bus.ic_cancel_o !== flt) begin bad++; $display("FAIL rnd_cancel cyc=%0d got=%0b want=%0b", i, bus.ic_cancel_o, flt); end
      total++; if (bus.valid_o !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", i, bus.valid_o, q.size() > 0); end
      if (q.size() > 0) begin
        total++;
        if (bus.pc_o !== q[0].pc || bus.inst_o !== q[0].inst || bus.exc_o !== q[0].exc || bus.ecode_o !== q[0].ecode
            || bus.is_tlbr_o !== (q[0].exc && q[0].ecode == 6'h3F)) begin
          bad++; $display("FAIL rnd_entry cyc=%0d got pc=%h inst=%h exc=%0b ecode=%h want pc=%h inst=%h exc=%0b ecode=%h",
                          i, bus.pc_o, bus.inst_o, bus.exc_o, bus.ecode_o, q[0].pc, q[0].inst, q[0].exc, q[0].ecode);
        end
      end
      if (bus.flush_i) begin
        q.delete();
        if (owed && rv) begin owed = 1'b0; drop = 1'b0; end
        else if (owed) drop = 1'b1;
      end else begin
        if (q.size() > 0 && !bus.stall_i) void'(q.pop_front());
        if (resp) q.push_back('{pc: req_pc, inst: bus.ic_rdata_i, exc: 1'b0, ecode: 6'h0});
        if (owed && rv) begin owed = 1'b0; drop = 1'b0; end
        if (flt) begin
          e.pc = bus.pc_i; e.inst = '0; e.exc = 1'b1;
          e.ecode = (bus.pc_i[1:0] != 2'b00) ? 6'h08 : bus.tlb_ecode_i;
          q.push_back(e);
        end
        if (acc && !flt) begin owed = 1'b1; req_pc = bus.pc_i; cnt = $urandom_range(0, 3); end
      end
      if (owed && !rv && cnt > 0) cnt--;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_aligned_hit();
    test_misaligned();
    test_tlb_refill();
    test_miss_flush();
    test_back_to_back();
    test_async_reset();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
